// File: rtl/s6_seq.sv
// Multi-cycle z = ((a % c) == zero) ? c + 1 : a - 1, using a restoring divider
// that retires one quotient bit per cycle behind a start/done handshake.
module s6_seq #(
   parameter int DATAWIDTH = 64
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic signed [DATAWIDTH-1:0] a,
   input  logic signed [DATAWIDTH-1:0] c,
   input  logic signed [DATAWIDTH-1:0] zero,
   output logic                        busy,
   output logic                        done,
   output logic signed [DATAWIDTH-1:0] z
);

   localparam int CW = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;
   localparam logic signed [DATAWIDTH-1:0] ONE = {{(DATAWIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      SIGN = 2'd2,
      OUT  = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic signed [DATAWIDTH-1:0] a_l, c_l, zero_l;
   logic        [DATAWIDTH-1:0] mag_a, mag_c, rem, rem_step, diff;
   logic        [DATAWIDTH:0]   shifted;
   logic        [CW-1:0]        cnt;
   logic signed [DATAWIDTH-1:0] rem_s, z_next;

   // |v| as an unsigned value; the most negative input maps to 2^(N-1) without overflow.
   function automatic logic [DATAWIDTH-1:0] magnitude(input logic signed [DATAWIDTH-1:0] v);
      logic [DATAWIDTH-1:0] u;
      u = v;
      return v[DATAWIDTH-1] ? (~u + ONE) : u;
   endfunction

   // Truncating remainder: sign follows the dividend; a zero divisor yields the dividend.
   function automatic logic signed [DATAWIDTH-1:0] signed_rem(
      input logic signed [DATAWIDTH-1:0] dividend,
      input logic signed [DATAWIDTH-1:0] divisor,
      input logic        [DATAWIDTH-1:0] r
   );
      if (divisor == '0) return dividend;
      if (dividend[DATAWIDTH-1]) return $signed(~r + ONE);
      return $signed(r);
   endfunction

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = DIV;
         end
         DIV:     if (cnt == '0) state_nxt = SIGN;
         SIGN:    state_nxt = OUT;
         OUT: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Restoring step: the partial remainder stays below |c|, so the low N bits of
   // the difference are exact whenever the subtraction is taken.
   always_comb begin
      shifted  = {rem, mag_a[cnt]};
      diff     = shifted[DATAWIDTH-1:0] - mag_c;
      rem_step = (shifted >= {1'b0, mag_c}) ? diff : shifted[DATAWIDTH-1:0];
      rem_s    = signed_rem(a_l, c_l, rem);
      z_next   = (rem_s == zero_l) ? (c_l + ONE) : (a_l - ONE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         a_l    <= '0;
         c_l    <= '0;
         zero_l <= '0;
         mag_a  <= '0;
         mag_c  <= '0;
         rem    <= '0;
         cnt    <= '0;
         z      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_l    <= a;
                  c_l    <= c;
                  zero_l <= zero;
                  mag_a  <= magnitude(a);
                  mag_c  <= magnitude(c);
                  rem    <= '0;
                  cnt    <= CW'(DATAWIDTH - 1);
               end
            end
            DIV: begin
               rem <= rem_step;
               cnt <= cnt - CW'(1);
            end
            SIGN:    z <= z_next;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_s6_seq.sv
// Scoreboard bench for s6_seq: stimulus pushes expected z and done cycle,
// an independent monitor pops and compares on every done pulse.
module tb_s6_seq;

   localparam logic signed [63:0] MIN = 64'sh8000_0000_0000_0000;
   localparam logic signed [63:0] MAX = 64'sh7FFF_FFFF_FFFF_FFFF;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               start = 1'b0;
   logic signed [63:0] a = '0;
   logic signed [63:0] c = '0;
   logic signed [63:0] zero = '0;
   logic               busy;
   logic               done;
   logic signed [63:0] z;

   typedef struct {
      logic signed [63:0] z;
      int unsigned        dc;
   } exp_t;

   exp_t        q[$];
   exp_t        mon_e;
   int unsigned cyc = 0;
   int unsigned last_k = 0;
   int          n_cmp = 0;
   int          n_bad = 0;

   s6_seq #(.DATAWIDTH(64)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .c     (c),
      .zero  (zero),
      .busy  (busy),
      .done  (done),
      .z     (z)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b required %b", name, act, exp);
      end
   endtask

   // Called on a negedge; start is sampled at the following posedge.
   task automatic issue(input logic signed [63:0] ta, input logic signed [63:0] tc,
                        input logic signed [63:0] tz, input logic signed [63:0] exp,
                        input bit push);
      start = 1'b1;
      a     = ta;
      c     = tc;
      zero  = tz;
      @(posedge clk);
      #1;
      last_k = cyc;
      if (push) q.push_back('{z: exp, dc: cyc + 65});
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_timeout: done stayed 0 for 200 cycles, required 1", name);
      end
   endtask

   task automatic after_done(input string name);
      @(negedge clk);
      check_bit({name, "_busy_low"}, busy, 1'b0);
      check_bit({name, "_done_low"}, done, 1'b0);
   endtask

   task automatic wait_cyc(input int unsigned target);
      while (cyc < target) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (rst === 1'b1 && done === 1'b1) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL spurious_done: done=1 z=%0d with nothing outstanding, required done=0", z);
         end else begin
            mon_e = q.pop_front();
            check("z", z, mon_e.z);
            check("done_cycle", 64'(cyc), 64'(mon_e.dc));
         end
      end
   end

   initial begin
      bit seen;
      int unsigned k0;

      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_bit("reset_busy", busy, 1'b0);
      check_bit("reset_done", done, 1'b0);
      check("reset_z", z, 64'sd0);
      rst = 1'b1;
      @(negedge clk);

      // basic equal and not-equal cases, issued back to back
      issue(64'sd10, 64'sd3, 64'sd1, 64'sd4, 1'b1);
      wait_done("t1");
      after_done("t1");
      issue(64'sd10, 64'sd3, 64'sd0, 64'sd9, 1'b1);
      wait_done("t2");
      after_done("t2");
      issue(-64'sd7, 64'sd3, -64'sd1, 64'sd4, 1'b1);
      wait_done("t3");
      after_done("t3");
      issue(64'sd7, -64'sd3, 64'sd1, -64'sd2, 1'b1);
      wait_done("t4");
      after_done("t4");

      // boundaries
      issue(MIN, -64'sd1, 64'sd0, 64'sd0, 1'b1);
      wait_done("b1");
      after_done("b1");
      issue(MIN, 64'sd5, 64'sd0, MAX, 1'b1);
      wait_done("b2");
      after_done("b2");
      issue(64'sd5, 64'sd0, 64'sd5, 64'sd1, 1'b1);
      wait_done("b3");
      after_done("b3");

      // start while busy is ignored; start right after done is accepted
      issue(64'sd20, 64'sd7, 64'sd6, 64'sd8, 1'b1);
      k0 = last_k;
      wait_cyc(k0 + 9);
      start = 1'b1;
      a = 64'sd9;
      c = 64'sd2;
      zero = 64'sd1;
      @(negedge clk);
      start = 1'b0;
      wait_cyc(k0 + 65);
      check_bit("ign_done_pulse", done, 1'b1);
      start = 1'b1;
      a = 64'sd3;
      c = 64'sd3;
      zero = 64'sd0;
      @(negedge clk);
      check_bit("ign_idle_after_done", busy, 1'b0);
      issue(-64'sd9, 64'sd4, -64'sd1, 64'sd5, 1'b1);
      wait_done("ign");
      after_done("ign");

      // reset in the middle of DIV aborts the request
      issue(64'sd100, 64'sd7, 64'sd2, 64'sd8, 1'b0);
      wait_cyc(last_k + 29);
      rst = 1'b0;
      @(negedge clk);
      check_bit("abort_busy", busy, 1'b0);
      check_bit("abort_done", done, 1'b0);
      check("abort_z", z, 64'sd0);
      rst = 1'b1;
      repeat (80) @(negedge clk);
      issue(64'sd100, 64'sd7, 64'sd2, 64'sd8, 1'b1);
      wait_done("fresh");
      after_done("fresh");

      // operands scrambled every cycle while busy
      issue(-64'sd100, 64'sd9, -64'sd1, 64'sd10, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         a    = {$urandom, $urandom};
         c    = {$urandom, $urandom};
         zero = {$urandom, $urandom};
         @(negedge clk);
      end
      if (!seen) begin
         n_cmp++;
         n_bad++;
         $display("FAIL hold_timeout: done stayed 0 for 200 cycles, required 1");
      end
      after_done("hold");
      repeat (5) @(negedge clk);
      check("z_hold", z, 64'sd10);

      repeat (3) @(negedge clk);
      check("leftover_expected", 64'(q.size()), 64'sd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
